// File: rtl/dpy_pkg.sv
// Shared types, digit codes and the seven-segment font for the multi-digit scanner.
// Segment bit order: seg[6:0] = a..g, seg[7] = decimal point.
package dpy_pkg;

    typedef logic [4:0] dcode_t;
    typedef logic [7:0] seg_t;

    localparam dcode_t DC_DASH  = 5'd16;
    localparam dcode_t DC_BLANK = 5'd17;

    localparam seg_t SEG_DASH  = 8'h40;
    localparam seg_t SEG_BLANK = 8'h00;

    typedef enum logic [1:0] {
        B2B_IDLE,
        B2B_SHIFT,
        B2B_DONE
    } b2b_state_t;

    // Lowercase b and d keep them distinct from 8 and 0.
    function automatic seg_t seg_font(input dcode_t code);
        case (code)
            5'd0:    seg_font = 8'h3F;
            5'd1:    seg_font = 8'h06;
            5'd2:    seg_font = 8'h5B;
            5'd3:    seg_font = 8'h4F;
            5'd4:    seg_font = 8'h66;
            5'd5:    seg_font = 8'h6D;
            5'd6:    seg_font = 8'h7D;
            5'd7:    seg_font = 8'h07;
            5'd8:    seg_font = 8'h7F;
            5'd9:    seg_font = 8'h6F;
            5'd10:   seg_font = 8'h77;
            5'd11:   seg_font = 8'h7C;
            5'd12:   seg_font = 8'h39;
            5'd13:   seg_font = 8'h5E;
            5'd14:   seg_font = 8'h79;
            5'd15:   seg_font = 8'h71;
            DC_DASH: seg_font = SEG_DASH;
            default: seg_font = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/dpy_scan_multi_if.sv
// Display bus: value/mode inputs from the client, digit-select and segment pins back out.
interface dpy_scan_multi_if #(
    parameter int DIGITS = 8
);
    logic [4*DIGITS-1:0] number;
    logic [DIGITS-1:0]   dp;
    logic                dec_mode;
    logic                blank_lz;
    logic [DIGITS-1:0]   sel;
    logic [7:0]          seg;
    logic                overflow;
    logic                busy;

    modport master (
        output number, dp, dec_mode, blank_lz,
        input  sel, seg, overflow, busy
    );

    modport slave (
        input  number, dp, dec_mode, blank_lz,
        output sel, seg, overflow, busy
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one input bit per cycle, start/busy/done handshake.
// The accumulator carries one spare BCD digit so the caller can detect overflow.
module bin2bcd_seq #(
    parameter int NUM_W  = 32,
    parameter int DIGITS = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_start,
    input  logic [NUM_W-1:0]          i_bin,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [4*(DIGITS+1)-1:0]   o_bcd,
    output logic                      o_lost
);
    import dpy_pkg::*;

    localparam int BCD_W = 4 * (DIGITS + 1);
    localparam int CNT_W = $clog2(NUM_W) + 1;

    b2b_state_t         r_state;
    b2b_state_t         w_next;
    logic [NUM_W-1:0]   r_bin;
    logic [BCD_W-1:0]   r_bcd;
    logic [BCD_W-1:0]   w_adj;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_lost;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= B2B_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            B2B_IDLE: begin
                if (i_start) w_next = B2B_SHIFT;
            end
            B2B_SHIFT: begin
                o_busy = 1'b1;
                if (r_cnt == CNT_W'(NUM_W - 1)) w_next = B2B_DONE;
            end
            B2B_DONE: begin
                o_busy = 1'b1;
                o_done = 1'b1;
                w_next = B2B_IDLE;
            end
            default: w_next = B2B_IDLE;
        endcase
    end

    always_comb begin
        w_adj = r_bcd;
        for (int k = 0; k <= DIGITS; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
        end
    end

    // A bit shifted out of the spare digit means the value needs more digits still.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_lost <= 1'b0;
        end else if (r_state == B2B_IDLE && i_start) begin
            r_bin  <= i_bin;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_lost <= 1'b0;
        end else if (r_state == B2B_SHIFT) begin
            r_bcd  <= {w_adj[BCD_W-2:0], r_bin[NUM_W-1]};
            r_bin  <= r_bin << 1;
            r_cnt  <= r_cnt + 1'b1;
            r_lost <= r_lost | w_adj[BCD_W-1];
        end
    end

    assign o_bcd  = r_bcd;
    assign o_lost = r_lost;

endmodule

// File: rtl/dpy_scan_multi.sv
// Parametrised seven-segment scanner with hex/decimal display, leading-zero blanking
// and decimal overflow dashes. Inputs are sampled once per frame so a frame never tears.
module dpy_scan_multi #(
    parameter int DIGITS  = 8,
    parameter int CLK_HZ  = 33_000_000,
    parameter int SCAN_HZ = 1000,
    parameter int GUARD   = 16
) (
    input  logic            clk,
    input  logic            rst,
    dpy_scan_multi_if.slave bus
);
    import dpy_pkg::*;

    localparam int NUM_W = 4 * DIGITS;
    localparam int BCD_W = 4 * (DIGITS + 1);
    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int PRE_W = $clog2(DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef dcode_t [DIGITS-1:0] disp_t;

    logic [PRE_W-1:0]  r_presc;
    logic [IDX_W-1:0]  r_idx;
    disp_t             r_disp;
    logic [DIGITS-1:0] r_dp;
    logic              r_ovf;
    logic [DIGITS-1:0] r_smp_dp;
    logic              r_smp_blz;
    logic [DIGITS-1:0] r_sel;
    seg_t              r_seg;

    logic              w_wrap;
    logic              w_frame;
    logic              w_start;
    logic              w_hex_load;
    logic              w_busy;
    logic              w_done;
    logic              w_lost;
    logic              w_dec_ovf;
    logic [BCD_W-1:0]  w_bcd;
    seg_t              w_font;

    // Blank every zero digit above the most-significant nonzero one; digit 0 always shows.
    function automatic disp_t lz_blank(input logic [NUM_W-1:0] nibs, input logic en);
        disp_t d;
        logic  lead;
        lead = en;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (lead && i != 0 && nibs[4*i +: 4] == 4'd0) begin
                d[i] = DC_BLANK;
            end else begin
                d[i] = dcode_t'({1'b0, nibs[4*i +: 4]});
                lead = 1'b0;
            end
        end
        return d;
    endfunction

    assign w_wrap     = (r_presc == PRE_W'(DIV - 1));
    assign w_frame    = w_wrap && (r_idx == IDX_W'(DIGITS - 1));
    assign w_start    = w_frame && !w_busy && bus.dec_mode;
    assign w_hex_load = w_frame && !w_busy && !bus.dec_mode;
    assign w_dec_ovf  = (w_bcd[BCD_W-1 -: 4] != 4'd0) || w_lost;

    bin2bcd_seq #(
        .NUM_W  (NUM_W),
        .DIGITS (DIGITS)
    ) u_b2b (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_bin   (bus.number),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_bcd   (w_bcd),
        .o_lost  (w_lost)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_wrap) begin
            r_presc <= '0;
            r_idx   <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // dp and blank_lz are held from the frame boundary until a decimal result lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp    <= '0;
            r_dp      <= '0;
            r_ovf     <= 1'b0;
            r_smp_dp  <= '0;
            r_smp_blz <= 1'b0;
        end else begin
            if (w_frame && !w_busy) begin
                r_smp_dp  <= bus.dp;
                r_smp_blz <= bus.blank_lz;
            end
            if (w_hex_load) begin
                r_disp <= lz_blank(bus.number, bus.blank_lz);
                r_dp   <= bus.dp;
                r_ovf  <= 1'b0;
            end else if (w_done) begin
                if (w_dec_ovf) begin
                    r_disp <= {DIGITS{DC_DASH}};
                    r_dp   <= '0;
                    r_ovf  <= 1'b1;
                end else begin
                    r_disp <= lz_blank(w_bcd[NUM_W-1:0], r_smp_blz);
                    r_dp   <= r_smp_dp;
                    r_ovf  <= 1'b0;
                end
            end
        end
    end

    assign w_font = seg_font(r_disp[r_idx]);

    // Guard window at the start of each slot keeps the previous digit from ghosting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel <= '0;
            r_seg <= SEG_BLANK;
        end else if (r_presc < PRE_W'(GUARD)) begin
            r_sel <= '0;
            r_seg <= SEG_BLANK;
        end else begin
            r_sel <= DIGITS'(1) << r_idx;
            r_seg <= {r_dp[r_idx], w_font[6:0]};
        end
    end

    assign bus.sel      = r_sel;
    assign bus.seg      = r_seg;
    assign bus.overflow = r_ovf;
    assign bus.busy     = w_busy;

    a_no_frame_while_busy : assert property (@(posedge clk) disable iff (rst) !(w_frame && w_busy));

endmodule

// File: tb/tb_dpy_scan_multi.sv
// Bench for dpy_scan_multi: value-level display model checked every cycle, plus literal pins.
module tb_dpy_scan_multi;

    localparam int ND  = 8;
    localparam int DV  = 10;
    localparam int GD  = 2;
    localparam int FRM = DV * ND;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dpy_scan_multi_if #(.DIGITS(ND)) bus ();

    dpy_scan_multi #(
        .DIGITS  (ND),
        .CLK_HZ  (1000),
        .SCAN_HZ (100),
        .GUARD   (GD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Character codes: 0..15 glyphs, 16 dash, 17 blank.
    function automatic logic [6:0] font7(input int ch);
        case (ch)
            0: font7 = 7'h3F;  1: font7 = 7'h06;  2: font7 = 7'h5B;  3: font7 = 7'h4F;
            4: font7 = 7'h66;  5: font7 = 7'h6D;  6: font7 = 7'h7D;  7: font7 = 7'h07;
            8: font7 = 7'h7F;  9: font7 = 7'h6F; 10: font7 = 7'h77; 11: font7 = 7'h7C;
           12: font7 = 7'h39; 13: font7 = 7'h5E; 14: font7 = 7'h79; 15: font7 = 7'h71;
           16: font7 = 7'h40;
           default: font7 = 7'h00;
        endcase
    endfunction

    function automatic longint p10(input int k);
        longint r;
        r = 1;
        for (int j = 0; j < k; j++) r = r * 10;
        return r;
    endfunction

    int          m_chr [ND];
    int          q_chr [ND];
    int          p_chr [ND];
    logic [ND-1:0] m_dp, q_dp, p_dp;
    bit          m_ovf, p_ovf, p_v;
    int          p_t, b_lo, b_hi;

    task automatic model_reset();
        for (int i = 0; i < ND; i++) begin
            m_chr[i] = 0;
            q_chr[i] = 0;
        end
        m_dp  = '0;
        q_dp  = '0;
        m_ovf = 1'b0;
        p_v   = 1'b0;
        b_lo  = 1;
        b_hi  = 0;
    endtask

    // What the display must become, computed from the value itself.
    task automatic model_sample(input int c);
        longint val;
        val = longint'(bus.number);
        if (bus.dec_mode) begin
            p_ovf = (val >= p10(ND));
            for (int i = 0; i < ND; i++) begin
                if (p_ovf) p_chr[i] = 16;
                else if (bus.blank_lz && i > 0 && val < p10(i)) p_chr[i] = 17;
                else p_chr[i] = int'((val / p10(i)) % 10);
            end
            p_dp = p_ovf ? '0 : bus.dp;
            p_t  = c + 4*ND + 2;
            b_lo = c + 1;
            b_hi = c + 4*ND + 1;
        end else begin
            p_ovf = 1'b0;
            for (int i = 0; i < ND; i++) begin
                if (bus.blank_lz && i > 0 && (val >> (4*i)) == 0) p_chr[i] = 17;
                else p_chr[i] = int'((val >> (4*i)) & 15);
            end
            p_dp = bus.dp;
            p_t  = c + 1;
        end
        p_v = 1'b1;
    endtask

    always @(negedge clk) begin : cmp
        int c, pi, ii;
        logic [ND-1:0] e_sel;
        logic [7:0]    e_seg;
        bit            e_busy;
        if (rst) begin
            model_reset();
            chk("rst_sel", 32'(bus.sel), 32'h0);
            chk("rst_seg", 32'(bus.seg), 32'h0);
            chk("rst_ovf", 32'(bus.overflow), 32'h0);
            chk("rst_busy", 32'(bus.busy), 32'h0);
        end else begin
            c     = cyc;
            e_sel = '0;
            e_seg = '0;
            if (c > 0) begin
                pi = (c - 1) % DV;
                ii = ((c - 1) / DV) % ND;
                if (pi >= GD) begin
                    e_sel = ND'(1) << ii;
                    e_seg = {q_dp[ii], font7(q_chr[ii])};
                end
            end
            if (p_v && c == p_t) begin
                m_chr = p_chr;
                m_dp  = p_dp;
                m_ovf = p_ovf;
                p_v   = 1'b0;
            end
            e_busy = (c >= b_lo) && (c <= b_hi);
            chk("sel", 32'(bus.sel), 32'(e_sel));
            chk("seg", 32'(bus.seg), 32'(e_seg));
            chk("overflow", 32'(bus.overflow), 32'(m_ovf));
            chk("busy", 32'(bus.busy), 32'(e_busy));
            if (c % FRM == FRM - 1 && !e_busy) model_sample(c);
            q_chr = m_chr;
            q_dp  = m_dp;
        end
    end

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
            if (guard > 3000) begin
                total++;
                bad++;
                $display("FAIL wait_cyc: cycle %0d never reached (at %0d)", n, cyc);
                return;
            end
        end while (cyc != n);
    endtask

    task automatic set_in(input logic [31:0] num, input logic [7:0] dpv,
                          input logic dm, input logic blz);
        #1;
        bus.number   = num;
        bus.dp       = dpv;
        bus.dec_mode = dm;
        bus.blank_lz = blz;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.number   = 32'h1234ABCD;
        bus.dp       = 8'h01;
        bus.dec_mode = 1'b0;
        bus.blank_lz = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Hex: reset display is all-zero code, then 1234ABCD with dp on digit 0.
        wait_cyc(5);   chk("t1_rst_sel", 32'(bus.sel), 32'h01); chk("t1_rst_seg", 32'(bus.seg), 32'h3F);
        wait_cyc(85);  chk("t1_d0_sel", 32'(bus.sel), 32'h01);  chk("t1_d0_seg", 32'(bus.seg), 32'hDE);
        wait_cyc(91);  chk("t1_guard", 32'(bus.sel), 32'h00);
        wait_cyc(95);  chk("t1_d1_sel", 32'(bus.sel), 32'h02);  chk("t1_d1_seg", 32'(bus.seg), 32'h39);
        wait_cyc(100); set_in(32'd12345678, 8'h00, 1'b1, 1'b0);
        wait_cyc(155); chk("t1_d7_sel", 32'(bus.sel), 32'h80);  chk("t1_d7_seg", 32'(bus.seg), 32'h06);

        // Decimal 12345678: busy 160..192, display holds until 193.
        wait_cyc(159); chk("t2_busy_pre", 32'(bus.busy), 32'h0);
        wait_cyc(160); chk("t2_busy_on", 32'(bus.busy), 32'h1);
        wait_cyc(165); chk("t2_hold_seg", 32'(bus.seg), 32'hDE);
        wait_cyc(192); chk("t2_busy_last", 32'(bus.busy), 32'h1);
        wait_cyc(193); chk("t2_busy_off", 32'(bus.busy), 32'h0);
        wait_cyc(245); chk("t2_d0_seg", 32'(bus.seg), 32'h7F);
        wait_cyc(250); set_in(32'd100000000, 8'hFF, 1'b1, 1'b0);
        wait_cyc(255); chk("t2_d1_seg", 32'(bus.seg), 32'h07); chk("t2_ovf", 32'(bus.overflow), 32'h0);

        // Overflow shows dashes without dp, then 99999999 with dp everywhere.
        wait_cyc(360); set_in(32'd99999999, 8'hFF, 1'b1, 1'b0);
        wait_cyc(385); chk("t3_dash_sel", 32'(bus.sel), 32'h40); chk("t3_dash_seg", 32'(bus.seg), 32'h40);
                       chk("t3_ovf_on", 32'(bus.overflow), 32'h1);
        wait_cyc(485); chk("t3_nine_seg", 32'(bus.seg), 32'hEF); chk("t3_ovf_off", 32'(bus.overflow), 32'h0);

        // Leading-zero blanking: 0, then 305.
        wait_cyc(490); set_in(32'd0, 8'h00, 1'b1, 1'b1);
        wait_cyc(645); chk("t4_zero_d0", 32'(bus.seg), 32'h3F);
        wait_cyc(650); set_in(32'd305, 8'h00, 1'b1, 1'b1);
        wait_cyc(655); chk("t4_zero_d1_sel", 32'(bus.sel), 32'h02); chk("t4_zero_d1_seg", 32'(bus.seg), 32'h00);
        wait_cyc(805); chk("t4_305_d0", 32'(bus.seg), 32'h6D);
        wait_cyc(815); chk("t4_305_d1", 32'(bus.seg), 32'h3F);
        wait_cyc(825); chk("t4_305_d2", 32'(bus.seg), 32'h4F);
        wait_cyc(835); chk("t4_305_d3_sel", 32'(bus.sel), 32'h08); chk("t4_305_d3_seg", 32'(bus.seg), 32'h00);

        // Back to hex mid-frame with blanking: A0 loads one cycle after the boundary.
        wait_cyc(840); set_in(32'h000000A0, 8'h00, 1'b0, 1'b1);
        wait_cyc(885); chk("t6_hex_d0", 32'(bus.seg), 32'h3F);
        wait_cyc(895); chk("t6_hex_d1", 32'(bus.seg), 32'h77);
        wait_cyc(905); chk("t6_hex_d2_sel", 32'(bus.sel), 32'h04); chk("t6_hex_d2_seg", 32'(bus.seg), 32'h00);

        // Reset in the middle of a conversion.
        wait_cyc(910); set_in(32'd87654321, 8'h00, 1'b1, 1'b0);
        wait_cyc(970); chk("t5_busy_mid", 32'(bus.busy), 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("t5_async_sel", 32'(bus.sel), 32'h0);
        chk("t5_async_seg", 32'(bus.seg), 32'h0);
        chk("t5_async_busy", 32'(bus.busy), 32'h0);
        chk("t5_async_ovf", 32'(bus.overflow), 32'h0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        wait_cyc(5);   chk("t5_restart_sel", 32'(bus.sel), 32'h01); chk("t5_restart_seg", 32'(bus.seg), 32'h3F);
                       chk("t5_restart_busy", 32'(bus.busy), 32'h0);
        wait_cyc(80);  chk("t5_conv_busy", 32'(bus.busy), 32'h1);
        wait_cyc(113); chk("t5_conv_done", 32'(bus.busy), 32'h0);
        wait_cyc(165); chk("t5_d0_seg", 32'(bus.seg), 32'h06);
        wait_cyc(175); chk("t5_d1_seg", 32'(bus.seg), 32'h5B);
        wait_cyc(180);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dpy_scan_multi.md
Name: dpy_scan_multi

Overview:
Parametrised seven-segment scanner, the successor to the fixed 8-digit hex scanner. Adds generic digit count, selectable hex or decimal display, leading-zero blanking and decimal overflow indication. Decimal mode uses a sequential binary-to-BCD converter. Lives in the clk_33m domain and drives the board digit-select and segment pins through mod_top.

Parameters:
DIGITS, 8, number of display digits; range 1..8.
CLK_HZ, 33_000_000, input clock frequency in Hz.
SCAN_HZ, 1000, per-digit dwell rate; DIV = CLK_HZ/SCAN_HZ cycles per digit, and DIV must be at least GUARD+2.
GUARD, 16, anti-ghosting cycles at the start of each digit slot, during which sel is all zero.
NUM_W, 4*DIGITS, binary input width (derived; do not override).

Ports:
clk  in  1  clock.
rst  in  1  reset, asynchronous, active-high.
number  in  NUM_W  value to display.
dp  in  DIGITS  decimal point per digit, active-high; bit 0 is the rightmost digit.
dec_mode  in  1  0 = hex, 1 = unsigned decimal.
blank_lz  in  1  1 = blank leading zeros.
sel  out  DIGITS  one-hot digit select, active-high.
seg  out  8  seg[6:0] = segments a..g, seg[7] = dp, active-high.
overflow  out  1  decimal value does not fit in DIGITS digits.
busy  out  1  BCD conversion in progress.

Behaviour:
- Reset: all outputs 0 (sel, seg, overflow, busy); digit index 0; prescaler 0; display register 0; FSM in IDLE. Reset during a conversion aborts it, and no partial result is latched.
- Prescaler:
  - Counts 0..DIV-1 and wraps.
  - On wrap, digit index advances by 1, with DIGITS-1 wrapping to 0.
- Digit output:
  - While prescaler < GUARD: sel = 0, seg = 0.
  - Otherwise: sel = one-hot(index), seg = font(display[index]) plus dp[index].
  - sel and seg are registered; they lag the prescaler/index by one cycle.
- Frame boundary is the cycle the index wraps to 0. number, dp, dec_mode and blank_lz are sampled only at a frame boundary, with no tearing within a frame.
- Hex mode: at a frame boundary the nibbles of number load directly into the display register on the next cycle. overflow = 0.
- Decimal mode conversion FSM:
  - IDLE: on a frame boundary, capture number and go to SHIFT. busy=1 from the next cycle.
  - SHIFT: NUM_W cycles of double-dabble (add 3 to any BCD nibble >= 5, then shift left). The BCD accumulator is 4*(DIGITS+1) bits wide to catch overflow.
  - DONE: one cycle. If the top BCD nibble != 0, set overflow=1 and load every display digit as dash (segment g only, no dp). Otherwise set overflow=0 and load the BCD digits. busy=0 and return to IDLE.
  - Latency from frame boundary to display update is NUM_W+2 cycles. The previous display holds until then.
  - A frame boundary while busy is ignored. This cannot occur when DIV*DIGITS > NUM_W+2, which is asserted in simulation.
- Leading-zero blanking, applied when the display loads:
  - Applies when blank_lz=1 and not overflow.
  - Blanks every digit above the most-significant nonzero digit; blanked digits get seg[6:0] = 0.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - dp bits are never blanked.
- Font: 0-9 and A-F (lowercase b and d), plus dash and blank codes. Mapping is fixed in the package.
- Mode change takes effect at the next frame boundary.

Decomposition:
- dpy_pkg holds:
  - digit code typedef: 5 bits (0-15 hex, DASH, BLANK).
  - seg_t (8 bits).
  - seg_font function.
  - SEG_DASH and SEG_BLANK constants.
- One sub-module, bin2bcd_seq:
  - Parametrised by NUM_W and DIGITS.
  - Handshake: start/busy/done.
  - Outputs: bcd [4*(DIGITS+1)-1:0].
  - Contains the IDLE/SHIFT/DONE FSM.
- Scanner, blanking and output registers stay in dpy_scan_multi.

Test Plan:
Test parameters throughout: DIGITS=8, CLK_HZ=1000, SCAN_HZ=100 (DIV=10), GUARD=2.
1. Hex mode, number=32'h1234ABCD, dp=8'h01: after one frame, sel cycles 01,02,..,80; seg codes read D,C,B,A,4,3,2,1 with dp on digit 0 only; sel=0 for 2 cycles of each slot.
2. Decimal mode, number=12345678: busy high for 32+1 cycles starting 1 cycle after the frame boundary; next frame shows 8,7,6,5,4,3,2,1; overflow=0.
3. Decimal mode, number=100000000 (> 99999999): overflow=1 and all 8 digits show dash; then number=99999999 gives overflow=0 and all 9s one frame later.
4. blank_lz=1, decimal, number=0: digit 0 shows "0" and digits 1..7 are blank. Then number=305: digits 0..2 show 5,0,3 and the rest are blank.
5. Assert rst mid-SHIFT: outputs go 0 immediately (async), busy=0, display=0. After release, scanning restarts at digit 0 and a fresh conversion completes on the first frame boundary.
6. Change number and dec_mode mid-frame: display stays unchanged until the next frame boundary, then updates with the documented latency (1 cycle hex, NUM_W+2 cycles decimal).
